// File: rtl/ll_axis_arb_mux_pkg.sv
// ll_axis_arb_mux_pkg: shared FSM encoding and rotate-index helper for the LocalLink-to-AXIS arbiter mux
package ll_axis_arb_mux_pkg;

  typedef enum logic {STATE_IDLE, STATE_XFER} state_t;

  function automatic int rr_index(input int ptr, input int k, input int ports);
    return (ptr + k) % ports;
  endfunction

endpackage

// File: rtl/ll_axis_rr_arbiter.sv
// ll_axis_rr_arbiter: combinational rotate-priority encoder, searching ptr+1, ptr+2, .. modulo PORTS
module ll_axis_rr_arbiter
  import ll_axis_arb_mux_pkg::*;
#(
  parameter int PORTS = 4,
  localparam int ID_WIDTH = $clog2(PORTS)
) (
  input  logic [PORTS-1:0]    request,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_index
);

  // Scan farthest-first so the nearest requester after ptr overwrites and wins
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    for (int k = PORTS; k >= 1; k--) begin
      if (request[rr_index(int'(ptr), k, PORTS)]) begin
        grant_valid = 1'b1;
        grant_index = ID_WIDTH'(rr_index(int'(ptr), k, PORTS));
      end
    end
  end

endmodule

// File: rtl/ll_axis_arb_mux.sv
// ll_axis_arb_mux: frame-based round-robin mux of PORTS LocalLink sources onto one registered AXI4-Stream output
module ll_axis_arb_mux
  import ll_axis_arb_mux_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_WIDTH = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] ll_data_in,
  input  logic [PORTS-1:0]            ll_sof_in_n,
  input  logic [PORTS-1:0]            ll_eof_in_n,
  input  logic [PORTS-1:0]            ll_src_rdy_in_n,
  output logic [PORTS-1:0]            ll_dst_rdy_out_n,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [ID_WIDTH-1:0]         m_axis_tid,
  output logic                        busy,
  output logic                        err_drop
);

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   grant, ptr, arb_index;
  logic [PORTS-1:0]      src_valid, request, drain, dst_rdy;
  logic                  arb_valid, can_accept, beat;
  logic [DATA_WIDTH-1:0] sel_data;

  assign src_valid  = ~ll_src_rdy_in_n;
  assign request    = src_valid & ~ll_sof_in_n;
  assign drain      = src_valid & ll_sof_in_n;
  assign can_accept = !m_axis_tvalid || m_axis_tready;
  assign beat       = (state == STATE_XFER) && src_valid[grant] && can_accept;
  assign sel_data   = ll_data_in[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign busy       = (state == STATE_XFER);

  ll_axis_rr_arbiter #(.PORTS(PORTS)) u_arbiter (
    .request     (request),
    .ptr         (ptr),
    .grant_valid (arb_valid),
    .grant_index (arb_index)
  );

  // Idle accepts only stray mid-frame beats (to discard them); the arbitration cycle itself moves no data
  always_comb begin
    state_nxt = state;
    dst_rdy   = '0;
    if (state == STATE_IDLE) begin
      dst_rdy   = drain;
      state_nxt = arb_valid ? STATE_XFER : STATE_IDLE;
    end else begin
      dst_rdy[grant] = can_accept;
      state_nxt      = (beat && !ll_eof_in_n[grant]) ? STATE_IDLE : STATE_XFER;
    end
  end

  assign ll_dst_rdy_out_n = rst_n ? ~dst_rdy : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STATE_IDLE;
      grant         <= '0;
      ptr           <= ID_WIDTH'(PORTS - 1);
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      err_drop      <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_drop <= (state == STATE_IDLE) && |drain;
      if (state == STATE_IDLE && arb_valid) begin
        grant <= arb_index;
        ptr   <= arb_index;
      end
      if (beat) begin
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= !ll_eof_in_n[grant];
        m_axis_tid    <= grant;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ll_axis_arb_mux.sv
// tb_ll_axis_arb_mux: randomized and directed checks of ll_axis_arb_mux against a frame-level reference model
module tb_ll_axis_arb_mux;
  localparam int PORTS = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [PORTS*DW-1:0] ll_data_in;
  logic [PORTS-1:0] sof_n, eof_n, src_rdy_n, dst_rdy_n;
  logic [DW-1:0] tdata;
  logic tvalid, tready, tlast, busy, err_drop;
  logic [1:0] tid;

  always #5 clk = ~clk;

  ll_axis_arb_mux #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ll_data_in       (ll_data_in),
    .ll_sof_in_n      (sof_n),
    .ll_eof_in_n      (eof_n),
    .ll_src_rdy_in_n  (src_rdy_n),
    .ll_dst_rdy_out_n (dst_rdy_n),
    .m_axis_tdata     (tdata),
    .m_axis_tvalid    (tvalid),
    .m_axis_tready    (tready),
    .m_axis_tlast     (tlast),
    .m_axis_tid       (tid),
    .busy             (busy),
    .err_drop         (err_drop)
  );

  typedef struct packed {logic [7:0] d; logic l; logic [1:0] id;} beat_t;

  beat_t exp_q[$];
  beat_t out_log[$];
  int frame_log[$];
  logic [8:0] pq[PORTS][$];
  bit launched[PORTS], first[PORTS], cur_v[PORTS];
  bit m_idle, m_ov, ready_pat;
  int m_ptr, m_grant, launch_pct, valid_pct, ready_pct, cyc;
  int tests = 0, fails = 0;
  bit pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < PORTS; p++) begin
      pq[p].delete();
      launched[p] = 0;
      first[p] = 1;
    end
    exp_q.delete();
    m_idle = 1;
    m_ov = 0;
    m_ptr = PORTS - 1;
    m_grant = 0;
  endtask

  task automatic add_frame(input int p, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) pq[p].push_back({i == len - 1, 8'(base + 8'(i))});
  endtask

  function automatic bit drained();
    bit e = m_idle && !m_ov && exp_q.size() == 0;
    for (int p = 0; p < PORTS; p++) e &= (pq[p].size() == 0);
    return e;
  endfunction

  // One clock of source behaviour plus the frame-level arbitration/output model
  task automatic step();
    bit arb, done;
    logic [3:0] xfer, xfer_exp;
    @(negedge clk);
    cyc++;
    for (int p = 0; p < PORTS; p++) begin
      if (!launched[p] && pq[p].size() > 0 && $urandom_range(99) < launch_pct) launched[p] = 1;
      cur_v[p] = launched[p] && ($urandom_range(99) < valid_pct);
      ll_data_in[p*DW +: DW] = cur_v[p] ? pq[p][0][7:0] : 8'($urandom);
      sof_n[p] = cur_v[p] ? !first[p] : 1'($urandom);
      eof_n[p] = cur_v[p] ? !pq[p][0][8] : 1'($urandom);
      src_rdy_n[p] = !cur_v[p];
    end
    tready = ready_pat ? pat[cyc % 6] : ($urandom_range(99) < ready_pct);
    #1;
    check("tvalid", tvalid, m_ov);
    if (m_ov) begin
      if (exp_q.size() == 0) check("exp_empty", 1, 0);
      else begin
        check("tdata", tdata, exp_q[0].d);
        check("tlast", tlast, exp_q[0].l);
        check("tid", tid, exp_q[0].id);
      end
    end
    check("busy", busy, !m_idle);
    check("err_drop", err_drop, 0);
    arb = 0;
    if (m_idle) begin
      for (int k = 1; k <= PORTS; k++) begin
        int q = (m_ptr + k) % PORTS;
        if (cur_v[q] && first[q]) begin
          m_grant = q;
          m_ptr = q;
          m_idle = 0;
          arb = 1;
          frame_log.push_back(q);
          for (int i = 0; i < pq[q].size(); i++) begin
            exp_q.push_back({pq[q][i][7:0], pq[q][i][8], 2'(q)});
            if (pq[q][i][8]) break;
          end
          break;
        end
      end
    end
    if (!m_idle && !arb) check("dst_rdy_grant", !dst_rdy_n[m_grant], !m_ov || tready);
    for (int p = 0; p < PORTS; p++) xfer[p] = cur_v[p] && !dst_rdy_n[p];
    xfer_exp = (!m_idle && !arb && cur_v[m_grant] && (!m_ov || tready)) ? 4'(1 << m_grant) : 4'b0;
    check("xfer_ports", xfer, xfer_exp);
    if (m_ov && tready) begin
      out_log.push_back({tdata, tlast, tid});
      if (exp_q.size() > 0) exp_q.pop_front();
    end
    done = 0;
    for (int p = 0; p < PORTS; p++) begin
      if (xfer[p]) begin
        bit eof = pq[p][0][8];
        pq[p].pop_front();
        first[p] = eof;
        if (eof) begin
          launched[p] = 0;
          done |= (p == m_grant);
        end
      end
    end
    m_ov = |xfer || (m_ov && !tready);
    if (done) m_idle = 1;
  endtask

  task automatic run(input string tag, input int max);
    int n = 0;
    while (!drained() && n < max) begin
      step();
      n++;
    end
    check(tag, drained(), 1);
  endtask

  task automatic mode(input int l, input int v, input int r, input bit pt);
    launch_pct = l;
    valid_pct = v;
    ready_pct = r;
    ready_pat = pt;
    frame_log.delete();
    out_log.delete();
  endtask

  initial begin
    rst_n = 0;
    src_rdy_n = '0;
    sof_n = '1;
    eof_n = '1;
    ll_data_in = '0;
    tready = 0;
    cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tid", tid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_drop, 0);
    check("rst_dst_rdy", dst_rdy_n, 4'hF);
    @(negedge clk);
    src_rdy_n = '1;
    rst_n = 1;

    mode(100, 100, 100, 0);
    add_frame(0, 3, 8'hA1);
    run("t1_drain", 50);
    check("t1_beats", out_log.size(), 3);
    check("t1_last", out_log[2].l, 1);

    mode(100, 100, 100, 0);
    add_frame(1, 2, 8'h10);
    add_frame(1, 2, 8'h20);
    add_frame(3, 2, 8'h30);
    add_frame(3, 2, 8'h40);
    run("t2_drain", 100);
    check("t2_frames", frame_log.size(), 4);
    foreach (frame_log[i]) check("t2_order", frame_log[i], (i % 2 == 0) ? 1 : 3);

    mode(100, 100, 0, 1);
    add_frame(2, 5, 8'h50);
    run("t3_drain", 100);
    check("t3_beats", out_log.size(), 5);
    foreach (out_log[i]) check("t3_data", out_log[i].d, 8'h50 + 8'(i));

    mode(100, 100, 100, 0);
    add_frame(0, 1, 8'h5C);
    run("t4_drain", 50);
    check("t4_beats", out_log.size(), 1);
    check("t4_data", out_log[0].d, 8'h5C);
    check("t4_last", out_log[0].l, 1);

    @(negedge clk);
    src_rdy_n = 4'b1101;
    sof_n = '1;
    eof_n = '1;
    ll_data_in = $urandom;
    tready = 1;
    #1;
    check("t5_drain_rdy", dst_rdy_n, 4'b1101);
    @(negedge clk);
    src_rdy_n = '1;
    #1;
    check("t5_err_pulse", err_drop, 1);
    check("t5_no_beat", tvalid, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    #1;
    check("t5_err_clear", err_drop, 0);
    check("t5_no_beat2", tvalid, 0);

    mode(30, 70, 70, 0);
    for (int p = 0; p < PORTS; p++)
      for (int f = 0; f < 15; f++) add_frame(p, $urandom_range(1, 5), 8'($urandom));
    run("rand_drain", 6000);
    check("rand_beats_nonzero", out_log.size() >= 60, 1);

    mode(100, 100, 100, 0);
    add_frame(3, 3, 8'h30);
    for (int n = 0; n < 50 && pq[3].size() != 2; n++) step();
    check("t6_first_beat", pq[3].size(), 2);
    @(negedge clk);
    src_rdy_n = 4'b0111;
    sof_n = '1;
    ll_data_in[3*DW +: DW] = 8'h31;
    rst_n = 0;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_dst_rdy", dst_rdy_n, 4'hF);
    check("t6_busy", busy, 0);
    model_reset();
    src_rdy_n = '1;
    @(negedge clk);
    rst_n = 1;
    mode(100, 100, 100, 0);
    add_frame(0, 2, 8'h60);
    add_frame(3, 2, 8'h70);
    run("t6_drain", 100);
    check("t6_frames", frame_log.size(), 2);
    check("t6_first_grant", frame_log[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
